fft_pe_feeder: RTL and testbench



---
 rtl/fft_pkg.sv | 18 +
 rtl/fft_feeder_bank.sv | 28 ++
 rtl/fft_pe_feeder.sv | 116 +++++++++++
 tb/tb_fft_pe_feeder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT front end.
// FFT_FEEDER_SCALE_EN (consumed by fft_pe_feeder) halves samples on entry.
package fft_pkg;
    localparam int FFT_N    = 16;
    localparam int FFT_HALF = FFT_N / 2;

    typedef logic signed [15:0] sample_t;

    typedef struct packed {
        sample_t re;
        sample_t im;
    } cplx_t;

    typedef enum logic {
        ST_IDLE,
        ST_DRAIN
    } drain_st_e;
endpackage

// File: rtl/fft_feeder_bank.sv
// Ping-pong sample store: two banks of N words, one write port and
// two combinational read ports returning x[k] and x[k+N/2].
module fft_feeder_bank
    import fft_pkg::*;
#(
    parameter int N  = FFT_N,
    parameter int DW = 16
) (
    input  logic                   clk,
    input  logic                   we_i,
    input  logic                   wbank_i,
    input  logic [$clog2(N)-1:0]   widx_i,
    input  logic [DW-1:0]          wdata_i,
    input  logic                   rbank_i,
    input  logic [$clog2(N)-2:0]   ridx_i,
    output logic [DW-1:0]          rd_lo_o,
    output logic [DW-1:0]          rd_hi_o
);
    logic [DW-1:0] mem_q [2][N];

    // Contents need no reset: the full flags gate every read.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[wbank_i][widx_i] <= wdata_i;
    end

    assign rd_lo_o = mem_q[rbank_i][{1'b0, ridx_i}];
    assign rd_hi_o = mem_q[rbank_i][{1'b1, ridx_i}];
endmodule

// File: rtl/fft_pe_feeder.sv
// Frames the FIR sample stream into N-sample ping-pong banks and drains each
// frame as first-stage butterfly pairs. Option: FFT_FEEDER_SCALE_EN (x>>>1 on entry).
module fft_pe_feeder
    import fft_pkg::*;
#(
    parameter int N  = FFT_N,
    parameter int DW = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DW-1:0]          fir_d,
    input  logic                   fir_valid,
    output logic                   fir_ready,
    output logic [2*DW-1:0]        a,
    output logic [2*DW-1:0]        b,
    output logic                   ab_valid,
    output logic [$clog2(N)-2:0]   power
);
    localparam int IW = $clog2(N);
    localparam int KW = IW - 1;
    localparam logic [KW-1:0] K_LAST = KW'(N / 2 - 1);
    localparam logic [IW-1:0] W_LAST = IW'(N - 1);

    logic            wr_bank_q, rd_bank_q;
    logic [IW-1:0]   wr_idx_q;
    logic [1:0]      full_q, full_d;
    logic [KW-1:0]   k_q;
    drain_st_e       state_q;
    logic [2*DW-1:0] a_q, b_q;
    logic [KW-1:0]   power_q;
    logic            vld_q;

    logic            fire, wr_last, rel;
    logic [DW-1:0]   wdata, rd_lo, rd_hi;

    assign fir_ready = !full_q[wr_bank_q];
    assign fire      = fir_valid && fir_ready;
    assign wr_last   = fire && (wr_idx_q == W_LAST);
    assign rel       = (state_q == ST_DRAIN) && (k_q == K_LAST);

`ifdef FFT_FEEDER_SCALE_EN
    assign wdata = $signed(fir_d) >>> 1;
`else
    assign wdata = fir_d;
`endif

    fft_feeder_bank #(.N(N), .DW(DW)) u_bank (
        .clk     (clk),
        .we_i    (fire),
        .wbank_i (wr_bank_q),
        .widx_i  (wr_idx_q),
        .wdata_i (wdata),
        .rbank_i (rd_bank_q),
        .ridx_i  (k_q),
        .rd_lo_o (rd_lo),
        .rd_hi_o (rd_hi)
    );

    // Writer can only complete a non-full bank and the drain only releases a
    // full one, so set and clear never target the same flag.
    always_comb begin
        full_d = full_q;
        if (rel)     full_d[rd_bank_q] = 1'b0;
        if (wr_last) full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx_q  <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= '0;
        end else begin
            full_q <= full_d;
            if (fire)    wr_idx_q  <= wr_idx_q + 1'b1;
            if (wr_last) wr_bank_q <= !wr_bank_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            rd_bank_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            power_q   <= '0;
            vld_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    vld_q <= 1'b0;
                    k_q   <= '0;
                    if (full_q[rd_bank_q]) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    a_q     <= {rd_lo, {DW{1'b0}}};
                    b_q     <= {rd_hi, {DW{1'b0}}};
                    power_q <= k_q;
                    vld_q   <= 1'b1;
                    k_q     <= k_q + 1'b1;
                    // k wraps to 0, so a full partner bank drains back-to-back
                    if (rel) begin
                        rd_bank_q <= !rd_bank_q;
                        if (!full_q[!rd_bank_q]) state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign power    = power_q;
    assign ab_valid = vld_q;
endmodule

// File: tb/tb_fft_pe_feeder.sv
// Scoreboard bench for fft_pe_feeder: the driver queues expected pairs as
// frames complete, a negedge monitor pops and checks them.
module tb_fft_pe_feeder;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] fir_d;
    logic        fir_valid;
    logic        fir_ready;
    logic [31:0] a, b;
    logic        ab_valid;
    logic [2:0]  power;

    always #5 clk = ~clk;

    fft_pe_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .fir_d     (fir_d),
        .fir_valid (fir_valid),
        .fir_ready (fir_ready),
        .a         (a),
        .b         (b),
        .ab_valid  (ab_valid),
        .power     (power)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  p;
        int          st;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] fbuf[$];
    int          cyc    = 0;
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] stored(input logic [15:0] d);
`ifdef FFT_FEEDER_SCALE_EN
        return {d[15], d[15:1]};
`else
        return d;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", nm, $time);
    endtask

    // Present one sample; on acceptance, feed the frame model.
    task automatic send(input logic [15:0] d, input bit chk_rdy);
        int n = 0;
        @(negedge clk);
        if (chk_rdy) chk("fir_ready_stream", {31'd0, fir_ready}, 32'd1);
        fir_valid = 1'b1;
        fir_d     = d;
        while (!fir_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!fir_ready) flag_fail("fir_ready_wait");
        @(posedge clk);
        fbuf.push_back(stored(d));
        if (fbuf.size() == 16) begin
            for (int k = 0; k < 8; k++) begin
                exp_t e;
                e.a  = {fbuf[k], 16'h0000};
                e.b  = {fbuf[k+8], 16'h0000};
                e.p  = 3'(k);
                e.st = (k == 0) ? cyc + 3 : -1;
                exp_q.push_back(e);
            end
            fbuf.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            fir_valid = 1'b0;
        end
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) flag_fail("drain_complete");
        idle(2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        fir_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        fbuf.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst && ab_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pair: got a=%h b=%h power=%0d with nothing queued", a, b, power);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pair_a", a, e.a);
                chk("pair_b", b, e.b);
                chk("power", {29'd0, power}, {29'd0, e.p});
                if (e.st >= 0) chk("first_pair_latency", cyc, e.st);
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        fir_valid = 1'b0;
        fir_d = '0;
        #3;
        chk("rst_a", a, 32'h0);
        chk("rst_b", b, 32'h0);
        chk("rst_power", {29'd0, power}, 32'd0);
        chk("rst_ab_valid", {31'd0, ab_valid}, 32'd0);
        chk("rst_fir_ready", {31'd0, fir_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Ramp 0..15
        for (int i = 0; i < 16; i++) send(16'(i), 1'b1);
        idle(1);
        wait_empty();

        // 48 back-to-back samples, three drains
        for (int i = 0; i < 48; i++) send(16'h1000 + 16'(i * 3), 1'b1);
        idle(1);
        wait_empty();

        // Withhold the 16th sample
        for (int i = 0; i < 15; i++) send(16'h0300 + 16'(i), 1'b1);
        repeat (6) begin
            @(negedge clk);
            fir_valid = 1'b0;
            #1 chk("no_valid_partial", {31'd0, ab_valid}, 32'd0);
        end
        send(16'h030F, 1'b1);
        idle(1);
        wait_empty();

        // Sign/scale edge values
        for (int i = 0; i < 16; i++) begin
            logic [15:0] v;
            case (i)
                0:       v = 16'h8000;
                1:       v = 16'h0001;
                2:       v = 16'hFFFF;
                8:       v = 16'h7FFF;
                9:       v = 16'hFFFE;
                default: v = 16'h0040 + 16'(i);
            endcase
            send(v, 1'b1);
        end
        idle(1);
        wait_empty();

        // Reset in the middle of a drain
        for (int i = 0; i < 16; i++) send(16'(i), 1'b1);
        idle(1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ab_valid && power == 3'd3) && n < 40);
        if (!(ab_valid && power == 3'd3)) flag_fail("reach_power3");
        #2 rst = 1'b1;
        #1;
        chk("midrst_ab_valid", {31'd0, ab_valid}, 32'd0);
        chk("midrst_a", a, 32'h0);
        chk("midrst_b", b, 32'h0);
        chk("midrst_power", {29'd0, power}, 32'd0);
        chk("midrst_fir_ready", {31'd0, fir_ready}, 32'd1);
        exp_q.delete();
        fbuf.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 100; i < 116; i++) send(16'(i), 1'b1);
        idle(1);
        wait_empty();

        // Both banks forced full: input must be refused
        for (int i = 0; i < 5; i++) send(16'h0500 + 16'(i), 1'b1);
        @(negedge clk);
        mon_en = 1'b0;
        force dut.full_q = 2'b11;
        repeat (4) begin
            @(negedge clk);
            fir_valid = 1'b1;
            fir_d = 16'hDEAD;
            #1;
            chk("forced_full_ready", {31'd0, fir_ready}, 32'd0);
            chk("forced_full_wr_idx", {28'd0, dut.wr_idx_q}, 32'd5);
        end
        @(negedge clk);
        fir_valid = 1'b0;
        release dut.full_q;
        do_reset();
        mon_en = 1'b1;

        // Recovery ramp
        for (int i = 0; i < 16; i++) send(16'h0700 + 16'(i), 1'b1);
        idle(1);
        wait_empty();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
